// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory.
// The arbiter uses the slave view; the requester/memory side uses the master view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8
);
   logic              i_req;
   logic [31:0]       i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [31:0]       i_rdata;
   logic              d_req;
   logic [31:0]       d_addr;
   logic [3:0]        d_wmask;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wmask;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_addr, mem_wmask, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_addr, mem_wmask, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch port and a data port.
// Grants are combinational; responses return one cycle after the grant.
module mem_arbiter #(
   parameter int ADDR_W = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   mem_arbiter_if.slave bus,
   output logic [15:0]  conflict_cnt
);

   typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

   state_t      state_q, state_d;
   logic        last_d_q, last_d_d;
   logic [15:0] cnt_q, cnt_d;
   logic        gnt_i, gnt_d, both_req;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign both_req = bus.i_req & bus.d_req;

   always_comb begin
      gnt_i    = 1'b0;
      gnt_d    = 1'b0;
      state_d  = IDLE;
      last_d_d = last_d_q;
      cnt_d    = cnt_q;
      // Grants are suppressed while reset is held; on conflict the port not served last wins.
      if (!RESET) begin
         if (both_req) begin
            gnt_i = last_d_q;
            gnt_d = ~last_d_q;
         end else begin
            gnt_i = bus.i_req;
            gnt_d = bus.d_req;
         end
      end
      if (gnt_i) begin
         state_d  = RESP_I;
         last_d_d = 1'b0;
      end else if (gnt_d) begin
         state_d  = RESP_D;
         last_d_d = 1'b1;
      end
      if (both_req) cnt_d = sat_inc(cnt_q);
   end

   always_comb begin
      bus.i_gnt     = gnt_i;
      bus.d_gnt     = gnt_d;
      bus.mem_en    = gnt_i | gnt_d;
      bus.mem_addr  = gnt_d ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
      bus.mem_wmask = gnt_d ? bus.d_wmask : 4'b0000;
      bus.mem_wdata = bus.d_wdata;
      bus.i_rvalid  = (state_q == RESP_I);
      bus.d_rvalid  = (state_q == RESP_D);
      bus.i_rdata   = bus.mem_rdata;
      bus.d_rdata   = bus.mem_rdata;
      conflict_cnt  = cnt_q;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;
         cnt_q    <= 16'd0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         cnt_q    <= cnt_d;
      end
   end

   // Byte-offset and high address bits are deliberately dropped (word addressing with wrap).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                               bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
   localparam int ADDR_W = 8;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [15:0] conflict_cnt;

   mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RESET(RESET), .bus(bus), .conflict_cnt(conflict_cnt)
   );

   always #5 CLK = ~CLK;

   // Shared memory: read data registered, read-before-write, byte-masked writes.
   logic [31:0] mem [256];
   always @(posedge CLK) begin
      if (bus.mem_en) begin
         bus.mem_rdata <= mem[bus.mem_addr];
         for (int b = 0; b < 4; b++)
            if (bus.mem_wmask[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   // Reference model state
   int          total = 0;
   int          bad = 0;
   logic [31:0] ref_mem [256];
   bit          last_was_d;
   int          exp_cnt;
   int          pend;        // 0 none, 1 fetch, 2 load, 3 store
   logic [31:0] pend_data;
   bit          g_i, g_d;

   bit          rir, rdr;
   logic [31:0] ria, rda, rdw;
   logic [3:0]  rdm;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      last_was_d = 1'b1;
      exp_cnt    = 0;
      pend       = 0;
   endtask

   task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                        input logic [3:0] dm, input logic [31:0] dw, input bit rst_after);
      int w;
      bus.i_req = ir; bus.i_addr = ia;
      bus.d_req = dr; bus.d_addr = da; bus.d_wmask = dm; bus.d_wdata = dw;
      #1;
      g_i = ir && (!dr || last_was_d);
      g_d = dr && !g_i;
      chk("i_gnt", 32'(bus.i_gnt), 32'(g_i));
      chk("d_gnt", 32'(bus.d_gnt), 32'(g_d));
      chk("mem_en", 32'(bus.mem_en), 32'(g_i | g_d));
      if (g_i || g_d) begin
         w = g_i ? int'((ia / 4) % 256) : int'((da / 4) % 256);
         chk("mem_addr", 32'(bus.mem_addr), 32'(w));
         chk("mem_wmask", 32'(bus.mem_wmask), g_d ? 32'(dm) : 32'd0);
         chk("mem_wdata", bus.mem_wdata, dw);
         pend_data = ref_mem[w];
         pend = g_i ? 1 : ((dm == 4'd0) ? 2 : 3);
         if (g_d)
            for (int b = 0; b < 4; b++)
               if (dm[b]) ref_mem[w][8*b +: 8] = dw[8*b +: 8];
         last_was_d = g_d;
      end else begin
         chk("mem_wmask_idle", 32'(bus.mem_wmask), 32'd0);
         pend = 0;
      end
      if (ir && dr && exp_cnt < 65535) exp_cnt++;
      @(posedge CLK);
      if (rst_after) begin
         RESET = 1'b1;
         model_reset();
      end
      #1;
      chk("i_rvalid", 32'(bus.i_rvalid), 32'(pend == 1));
      chk("d_rvalid", 32'(bus.d_rvalid), 32'(pend >= 2));
      if (pend == 1) chk("i_rdata", bus.i_rdata, pend_data);
      if (pend == 2) chk("d_rdata", bus.d_rdata, pend_data);
      chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
   endtask

   // Holds/asserts reset with both ports requesting, checks quiet outputs, then releases.
   task automatic reset_phase();
      RESET = 1'b1;
      model_reset();
      bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_wmask = 4'hF;
      #1;
      chk("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
      chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
      chk("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      chk("rst_cnt", 32'(conflict_cnt), 32'd0);
      @(posedge CLK); #1;
      chk("rst_cnt_held", 32'(conflict_cnt), 32'd0);
      chk("rst_i_rvalid_held", 32'(bus.i_rvalid), 32'd0);
      bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_wmask = 4'h0;
      RESET = 1'b0;
   endtask

   initial begin
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wmask = '0; bus.d_wdata = '0;
      model_reset();
      #1;
      reset_phase();

      // Preload every word through the data port
      for (int w = 0; w < 256; w++) begin
         logic [31:0] v;
         v = (w == 4) ? 32'hCAFE0004 : (w == 8) ? 32'h11223344 : $urandom;
         cycle(1'b0, 32'd0, 1'b1, 32'(w * 4), 4'hF, v, 1'b0);
      end

      // Single fetch of byte address 0x10
      cycle(1'b1, 32'h0000_0010, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0);
      chk("fetch_word4", bus.i_rdata, 32'hCAFE0004);

      // Partial store then load
      cycle(1'b0, 32'd0, 1'b1, 32'h20, 4'b0011, 32'hAABBCCDD, 1'b0);
      cycle(1'b0, 32'd0, 1'b1, 32'h20, 4'b0000, 32'd0, 1'b0);
      chk("store_load", bus.d_rdata, 32'h1122CCDD);

      // Address wrap: 0x404 maps onto word 1
      cycle(1'b0, 32'd0, 1'b1, 32'h0000_0404, 4'b0000, 32'd0, 1'b0);
      chk("wrap_word1", bus.d_rdata, ref_mem[1]);

      // Conflict right after reset: fetch first, then alternate
      reset_phase();
      repeat (4) cycle(1'b1, 32'h40, 1'b1, 32'h80, 4'b0000, 32'd0, 1'b0);
      chk("conflict_cnt4", 32'(conflict_cnt), 32'd4);

      // Reset in the response cycle of a fetch discards the response
      cycle(1'b1, 32'h0000_0010, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1);
      reset_phase();
      cycle(1'b1, 32'h44, 1'b1, 32'h84, 4'b0000, 32'd0, 1'b0);
      chk("post_rst_fetch_first", 32'(bus.i_rvalid), 32'd1);

      // Randomized traffic; a request stays up with stable fields until granted
      rir = 1'b0; rdr = 1'b0;
      repeat (400) begin
         if (!rir) begin
            rir = 1'($urandom_range(0, 1));
            ria = $urandom;
         end
         if (!rdr) begin
            rdr = 1'($urandom_range(0, 1));
            rda = $urandom;
            rdm = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            rdw = $urandom;
         end
         cycle(rir, ria, rdr, rda, rdm, rdw, 1'b0);
         if (g_i) rir = 1'b0;
         if (g_d) rdr = 1'b0;
      end

      // Counter saturation
      reset_phase();
      repeat (65540) cycle(1'b1, $urandom, 1'b1, $urandom, 4'h0, 32'd0, 1'b0);
      chk("cnt_saturated", 32'(conflict_cnt), 32'h0000_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
